// File: rtl/gpio_bus_arb.sv
// rtl/gpio_bus_arb.sv - round-robin arbiter sharing one GPIO register port between bus masters
module gpio_bus_arb #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        m_req_i,
    input  logic [NUM_REQ-1:0]        m_w_en_i,
    input  logic [NUM_REQ*ADDR_W-1:0] m_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] m_w_data_i,
    output logic [NUM_REQ-1:0]        m_ack_o,
    output logic [NUM_REQ-1:0]        m_err_o,
    output logic [DATA_W-1:0]         m_r_data_o,
    output logic                      s_req_o,
    output logic                      s_sel_o,
    output logic                      s_w_en_o,
    output logic [ADDR_W-1:0]         s_addr_o,
    output logic [DATA_W-1:0]         s_w_data_o,
    input  logic                      s_ack_i,
    input  logic [DATA_W-1:0]         s_r_data_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic                      busy_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [PTR_W-1:0]    rr_ptr;
    logic [PTR_W-1:0]    g_idx;
    logic [PTR_W-1:0]    win_idx;
    logic [PTR_W-1:0]    ptr_after_g;
    logic                win_vld;
    logic [NUM_REQ-1:0]  gnt;
    logic [TMR_W-1:0]    timer;
    logic                cmd_w_en;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [DATA_W-1:0]   cmd_w_data;
    logic                tmo_hit;
    logic                done;

    // First requester at or after rr_ptr, wrapping around.
    always_comb begin
        int k;
        k       = 0;
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = (int'(rr_ptr) + i) % NUM_REQ;
            if (!win_vld && m_req_i[k]) begin
                win_vld = 1'b1;
                win_idx = PTR_W'(k);
            end
        end
    end

    assign ptr_after_g = (int'(g_idx) == NUM_REQ - 1) ? '0 : g_idx + 1'b1;
    assign tmo_hit     = (TIMEOUT != 0) && (timer == TMR_LAST);
    assign done        = (state == BUSY) && (s_ack_i || tmo_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            g_idx      <= '0;
            gnt        <= '0;
            timer      <= '0;
            cmd_w_en   <= 1'b0;
            cmd_addr   <= '0;
            cmd_w_data <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                if (win_vld) begin
                    gnt        <= NUM_REQ'(1) << win_idx;
                    g_idx      <= win_idx;
                    cmd_w_en   <= m_w_en_i[win_idx];
                    cmd_addr   <= m_addr_i[win_idx*ADDR_W +: ADDR_W];
                    cmd_w_data <= m_w_data_i[win_idx*DATA_W +: DATA_W];
                    timer      <= '0;
                end
            end else if (done) begin
                gnt    <= '0;
                rr_ptr <= ptr_after_g;
            end else begin
                timer <= timer + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_vld) state_nxt = BUSY;
            BUSY:    if (done)    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // An ack arriving together with the timeout wins, so err only flags a true timeout.
    always_comb begin
        busy_o     = (state == BUSY);
        s_req_o    = busy_o;
        s_sel_o    = busy_o;
        s_w_en_o   = busy_o & cmd_w_en;
        s_addr_o   = busy_o ? cmd_addr : '0;
        s_w_data_o = busy_o ? cmd_w_data : '0;
        gnt_o      = gnt;
        m_ack_o    = done ? gnt : '0;
        m_err_o    = (done && !s_ack_i) ? gnt : '0;
        m_r_data_o = '0;
        if (done) m_r_data_o = s_ack_i ? s_r_data_i : '1;
    end

endmodule

// File: tb/tb_gpio_bus_arb.sv
// tb/tb_gpio_bus_arb.sv - scoreboard bench for gpio_bus_arb
module tb_gpio_bus_arb;
    localparam int NR = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 15;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NR-1:0]    m_req = '0;
    logic [NR-1:0]    m_w_en = '0;
    logic [NR*AW-1:0] m_addr = '0;
    logic [NR*DW-1:0] m_w_data = '0;
    logic [NR-1:0]    m_ack;
    logic [NR-1:0]    m_err;
    logic [DW-1:0]    m_r_data;
    logic             s_req, s_sel, s_w_en;
    logic [AW-1:0]    s_addr;
    logic [DW-1:0]    s_w_data;
    logic             s_ack;
    logic             model_ack;
    logic             inj_ack = 1'b0;
    logic             model_en = 1'b1;
    logic [DW-1:0]    s_r_data = '0;
    logic [NR-1:0]    gnt;
    logic             busy;

    always #5 clk = ~clk;

    gpio_bus_arb #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_req_i(m_req), .m_w_en_i(m_w_en), .m_addr_i(m_addr), .m_w_data_i(m_w_data),
        .m_ack_o(m_ack), .m_err_o(m_err), .m_r_data_o(m_r_data),
        .s_req_o(s_req), .s_sel_o(s_sel), .s_w_en_o(s_w_en), .s_addr_o(s_addr),
        .s_w_data_o(s_w_data), .s_ack_i(s_ack), .s_r_data_i(s_r_data),
        .gnt_o(gnt), .busy_o(busy)
    );

    // GPIO model: registered ack one cycle after req
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_ack <= 1'b0;
        else        model_ack <= model_en & s_req & ~model_ack;
    end
    assign s_ack = model_ack | inj_ack;

    typedef struct {
        logic [NR-1:0] ack;
        logic          err;
        logic [DW-1:0] rdata;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    int            cyc = 0;
    int            n_pass = 0;
    int            n_total = 0;
    logic [NR-1:0] drop = '0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    endtask

    task automatic expect_ack(input logic [NR-1:0] a, input logic e, input logic [DW-1:0] d, input int c);
        sb.push_back('{a, e, d, c});
    endtask

    task automatic set_m(input int i, input logic req, input logic wen,
                         input logic [AW-1:0] addr, input logic [DW-1:0] data);
        m_req[i]              = req;
        m_w_en[i]             = wen;
        m_addr[i*AW +: AW]    = addr;
        m_w_data[i*DW +: DW]  = data;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NR; i++) begin
            if (drop[i]) begin
                m_req[i] = 1'b0;
                drop[i]  = 1'b0;
            end
        end
    endtask

    task automatic settle();
        exp_t e;
        #1;
        if (|m_ack) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", 64'(m_ack), 64'd0);
            end else begin
                e = sb.pop_front();
                check("ack_vec", 64'(m_ack), 64'(e.ack));
                check("ack_err", 64'(m_err), e.err ? 64'(e.ack) : 64'd0);
                check("ack_rdata", 64'(m_r_data), 64'(e.rdata));
                check("ack_cycle", 64'(cyc), 64'(e.cyc));
            end
            drop = drop | m_ack;
        end else begin
            check("idle_rsp", 64'({m_err, m_r_data}), 64'd0);
        end
    endtask

    task automatic step();
        tick();
        settle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        m_req    = '0;
        inj_ack  = 1'b0;
        model_en = 1'b1;
        drop     = '0;
        #1;
        check("rst_ctrl", 64'({s_req, s_sel, s_w_en, busy, gnt, m_ack, m_err}), 64'd0);
        check("rst_bus", 64'({s_addr, m_r_data}), 64'd0);
        check("sb_drained", 64'(sb.size()), 64'd0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = -1;
    endtask

    initial begin
        // single write from m0
        do_reset();
        s_r_data = 32'h1234_5678;
        tick();
        set_m(0, 1'b1, 1'b1, 32'h04, 32'hFF);
        expect_ack(2'b01, 1'b0, 32'h1234_5678, 2);
        settle();
        check("w_c0_busy", 64'(busy), 64'd0);
        step();
        check("w_c1_req", 64'({s_req, s_sel, s_w_en}), 64'b111);
        check("w_c1_addr", 64'(s_addr), 64'h04);
        check("w_c1_wdata", 64'(s_w_data), 64'hFF);
        check("w_c1_gnt", 64'(gnt), 64'b01);
        step();
        step();
        check("w_c3_req", 64'(s_req), 64'd0);
        check("w_c3_gnt", 64'(gnt), 64'd0);

        // contention and alternation
        do_reset();
        s_r_data = 32'h11;
        tick();
        set_m(0, 1'b1, 1'b0, 32'h00, 32'h0);
        set_m(1, 1'b1, 1'b1, 32'h08, 32'h55);
        expect_ack(2'b01, 1'b0, 32'h11, 2);
        expect_ack(2'b10, 1'b0, 32'h11, 5);
        expect_ack(2'b01, 1'b0, 32'h11, 8);
        settle();
        step();
        step();
        step();
        check("alt_c3_gnt", 64'(gnt), 64'd0);
        tick();
        set_m(0, 1'b1, 1'b1, 32'h0C, 32'h77);
        settle();
        check("alt_c4_gnt", 64'(gnt), 64'b10);
        check("alt_c4_addr", 64'(s_addr), 64'h08);
        step();
        step();
        check("alt_c6_idle", 64'(busy), 64'd0);
        step();
        check("alt_c7_gnt", 64'(gnt), 64'b01);
        check("alt_c7_addr", 64'(s_addr), 64'h0C);
        step();
        step();

        // m1 read
        do_reset();
        s_r_data = 32'hA5;
        tick();
        set_m(1, 1'b1, 1'b0, 32'h00, 32'h0);
        expect_ack(2'b10, 1'b0, 32'h0000_00A5, 2);
        settle();
        step();
        check("rd_c1_wen", 64'(s_w_en), 64'd0);
        check("rd_c1_gnt", 64'(gnt), 64'b10);
        step();
        step();

        // timeout, GPIO never answers
        do_reset();
        model_en = 1'b0;
        tick();
        set_m(0, 1'b1, 1'b0, 32'h10, 32'h0);
        expect_ack(2'b01, 1'b1, 32'hFFFF_FFFF, TO);
        settle();
        for (int c = 1; c <= TO; c++) begin
            step();
            check("to_sreq", 64'(s_req), 64'd1);
        end
        step();
        check("to_c16_idle", 64'({s_req, busy}), 64'd0);

        // ack on the timeout cycle wins
        do_reset();
        model_en = 1'b0;
        tick();
        set_m(0, 1'b1, 1'b0, 32'h10, 32'h0);
        expect_ack(2'b01, 1'b0, 32'h3C, TO);
        settle();
        for (int c = 1; c < TO; c++) step();
        tick();
        inj_ack  = 1'b1;
        s_r_data = 32'h3C;
        settle();
        tick();
        inj_ack = 1'b0;
        settle();
        check("tie_c16_idle", 64'(busy), 64'd0);

        // reset during BUSY, late ack, then fresh arbitration
        do_reset();
        model_en = 1'b0;
        tick();
        set_m(0, 1'b1, 1'b1, 32'h20, 32'h1);
        settle();
        step();
        check("rb_c1_req", 64'(s_req), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rb_req_drop", 64'(s_req), 64'd0);
        m_req = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = -1;
        tick();
        inj_ack = 1'b1;
        settle();
        check("late_ack", 64'(m_ack), 64'd0);
        check("late_gnt", 64'(gnt), 64'd0);
        tick();
        inj_ack  = 1'b0;
        model_en = 1'b1;
        s_r_data = 32'h5A;
        set_m(0, 1'b1, 1'b0, 32'h00, 32'h0);
        set_m(1, 1'b1, 1'b0, 32'h04, 32'h0);
        expect_ack(2'b01, 1'b0, 32'h5A, 3);
        expect_ack(2'b10, 1'b0, 32'h5A, 6);
        settle();
        step();
        check("rb_c2_gnt", 64'(gnt), 64'b01);
        step();
        step();
        step();
        check("rb_c5_gnt", 64'(gnt), 64'b10);
        step();
        step();

        check("sb_final", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
